// File: rtl/voice_mixer.sv
// Per-voice volume mixer: snapshots all voices on each sample_clock rising edge,
// accumulates sample*gain one voice per clk, then saturates and emits one PCM word.
module voice_mixer #(
  parameter int NVOICES  = 4,
  parameter int BITDEPTH = 14,
  parameter int VOLBITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_sample_clock,
  input  logic [NVOICES*BITDEPTH-1:0] i_voice_in,
  input  logic                        i_vol_wen,
  input  logic [3:0]                  i_vol_addr,
  input  logic [VOLBITS-1:0]          i_vol_data,
  output logic [BITDEPTH-1:0]         o_pcm_out,
  output logic                        o_pcm_valid,
  output logic                        o_busy,
  output logic                        o_overrun
);

  localparam int PW = BITDEPTH + VOLBITS + 1;
  localparam int AW = PW + $clog2(NVOICES);
  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  localparam logic [BITDEPTH-1:0]  MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic [VOLBITS-1:0]   VOL_RST  = VOLBITS'(1 << (VOLBITS - 2));
  localparam logic signed [AW-1:0] SAT_MAX  = AW'((1 << (BITDEPTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_sc_q;
  logic                   w_edge;
  logic [VOLBITS-1:0]     r_vol        [NVOICES];
  logic [BITDEPTH-1:0]    r_snap_voice [NVOICES];
  logic [VOLBITS-1:0]     r_snap_vol   [NVOICES];
  logic signed [AW-1:0]   r_acc;
  logic [IW-1:0]          r_idx;
  logic [BITDEPTH-1:0]    r_pcm_out;
  logic                   r_pcm_valid;
  logic                   r_overrun;

  logic [BITDEPTH-1:0]        w_sel_voice;
  logic [VOLBITS-1:0]         w_sel_vol;
  logic signed [PW-1:0]       w_s_ext;
  logic signed [PW-1:0]       w_v_ext;
  logic signed [PW-1:0]       w_prod;
  logic signed [AW-1:0]       w_shift;
  logic [BITDEPTH-1:0]        w_sat;

  assign w_edge = i_sample_clock & ~r_sc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal driven in always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_edge) w_next_state = S_ACCUM;
      S_ACCUM: if (r_idx == IW'(NVOICES - 1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_q <= 1'b0;
      for (int i = 0; i < NVOICES; i++) r_vol[i] <= VOL_RST;
    end else begin
      r_sc_q <= i_sample_clock;
      for (int i = 0; i < NVOICES; i++)
        if (i_vol_wen && i_vol_addr == 4'(i)) r_vol[i] <= i_vol_data;
    end
  end

  // NOTE: snapshot registers carry no reset; they are always loaded before
  // being read, and leaving them out of reset keeps them plain flops.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_edge) begin
      for (int i = 0; i < NVOICES; i++) begin
        r_snap_voice[i] <= i_voice_in[i*BITDEPTH +: BITDEPTH];
        r_snap_vol[i]   <= r_vol[i];
      end
    end
  end

  always_comb begin
    w_sel_voice = '0;
    w_sel_vol   = '0;
    for (int i = 0; i < NVOICES; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel_voice = r_snap_voice[i];
        w_sel_vol   = r_snap_vol[i];
      end
    end
  end

  // Offset binary to two's complement is an MSB flip.
  assign w_s_ext = PW'($signed({~w_sel_voice[BITDEPTH-1], w_sel_voice[BITDEPTH-2:0]}));
  assign w_v_ext = {{(PW-VOLBITS){1'b0}}, w_sel_vol};
  assign w_prod  = w_s_ext * w_v_ext;
  assign w_shift = r_acc >>> VOLBITS;

  always_comb begin
    if (w_shift > SAT_MAX)      w_sat = {1'b0, {(BITDEPTH-1){1'b1}}};
    else if (w_shift < SAT_MIN) w_sat = {1'b1, {(BITDEPTH-1){1'b0}}};
    else                        w_sat = w_shift[BITDEPTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_idx       <= '0;
      r_pcm_out   <= MIDSCALE;
      r_pcm_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_pcm_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_edge) begin
          r_acc <= '0;
          r_idx <= '0;
        end
        S_ACCUM: begin
          r_acc <= r_acc + AW'(w_prod);
          r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          r_pcm_out   <= w_sat ^ MIDSCALE;
          r_pcm_valid <= 1'b1;
        end
        default: ;
      endcase
      if (w_edge && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  end

  assign o_pcm_out   = r_pcm_out;
  assign o_pcm_valid = r_pcm_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Randomized bench for voice_mixer against an integer-arithmetic mixing model,
// plus directed cases for clamping, snapshotting, overrun and mid-mix reset.
module tb_voice_mixer;

  localparam int NV = 4;
  localparam int BD = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            sc;
  logic [NV*BD-1:0] voice_bus;
  logic            wen;
  logic [3:0]      waddr;
  logic [7:0]      wdata;
  logic [BD-1:0]   pcm_out;
  logic            pcm_valid;
  logic            busy;
  logic            overrun;

  int vin   [NV];
  int m_vol [NV];
  int exp_overrun;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    voice_bus = '0;
    for (int i = 0; i < NV; i++) voice_bus[i*BD +: BD] = BD'(vin[i]);
  end

  voice_mixer #(.NVOICES(NV), .BITDEPTH(BD), .VOLBITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_sample_clock(sc),
    .i_voice_in    (voice_bus),
    .i_vol_wen     (wen),
    .i_vol_addr    (waddr),
    .i_vol_data    (wdata),
    .o_pcm_out     (pcm_out),
    .o_pcm_valid   (pcm_valid),
    .o_busy        (busy),
    .o_overrun     (overrun)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Gain-weighted sum of signed samples, floor-divided by 256, clamped, re-offset.
  function automatic int mix();
    int acc = 0;
    for (int i = 0; i < NV; i++) acc += (vin[i] - 8192) * m_vol[i];
    acc = acc >>> 8;
    if (acc > 8191)  acc = 8191;
    if (acc < -8192) acc = -8192;
    return acc + 8192;
  endfunction

  task automatic wr_vol(input int addr, input int data);
    @(negedge clk);
    wen = 1'b1; waddr = 4'(addr); wdata = 8'(data);
    @(negedge clk);
    wen = 1'b0;
    if (addr < NV) m_vol[addr] = data;
  endtask

  // mode 0: plain sample; 1: volume write during ACCUM; 2: second edge while busy
  task automatic do_sample(input string tag, input int mode, input int wa, input int wd);
    int exp_pcm, cnt, extra;
    exp_pcm = mix();
    @(negedge clk);
    sc = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy"}, int'(busy), 1);
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      if (pcm_valid) break;
      if (cnt == 1) begin
        sc = 1'b0;
        if (mode == 1) begin wen = 1'b1; waddr = 4'(wa); wdata = 8'(wd); end
      end
      if (cnt == 2) begin
        wen = 1'b0;
        if (mode == 2) sc = 1'b1;
      end
      if (cnt == 3) sc = 1'b0;
    end
    sc = 1'b0; wen = 1'b0;
    if (mode == 1 && wa < NV) m_vol[wa] = wd;
    if (mode == 2) exp_overrun = 1;
    check({tag, "_latency"}, cnt, 5);
    check({tag, "_pcm"}, int'(pcm_out), exp_pcm);
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (pcm_valid) extra++;
    end
    check({tag, "_extra_valid"}, extra, 0);
    check({tag, "_idle"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), exp_overrun);
    check({tag, "_hold"}, int'(pcm_out), exp_pcm);
  endtask

  function automatic int rnd_voice();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 16383;
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  initial begin
    int extra;
    rst = 1'b1; sc = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
    exp_overrun = 0;
    for (int i = 0; i < NV; i++) begin vin[i] = 8192; m_vol[i] = 64; end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pcm", int'(pcm_out), 8192);
    check("rst_valid", int'(pcm_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    do_sample("mid", 0, 0, 0);

    wr_vol(0, 255); wr_vol(1, 0); wr_vol(2, 0); wr_vol(3, 0);
    vin[0] = 16383; vin[1] = 0; vin[2] = 5; vin[3] = 16383;
    do_sample("v0_max", 0, 0, 0);
    check("v0_max_const", int'(pcm_out), 16351);
    vin[0] = 0;
    do_sample("v0_min", 0, 0, 0);
    check("v0_min_const", int'(pcm_out), 32);

    for (int i = 0; i < NV; i++) wr_vol(i, 255);
    for (int i = 0; i < NV; i++) vin[i] = 16383;
    do_sample("clamp_hi", 0, 0, 0);
    check("clamp_hi_const", int'(pcm_out), 16383);
    for (int i = 0; i < NV; i++) vin[i] = 0;
    do_sample("clamp_lo", 0, 0, 0);
    check("clamp_lo_const", int'(pcm_out), 0);

    for (int i = 0; i < NV; i++) vin[i] = 12000;
    do_sample("wr_accum", 1, 0, 3);
    do_sample("wr_after", 0, 0, 0);
    wr_vol(7, 0);
    do_sample("wr_addr7", 0, 0, 0);

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NV; i++) vin[i] = rnd_voice();
      repeat ($urandom_range(0, 2)) wr_vol(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      do_sample($sformatf("rnd%0d", it), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end

    do_sample("overrun", 2, 0, 0);

    @(negedge clk);
    sc = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sc = 1'b0;
    for (int i = 0; i < NV; i++) m_vol[i] = 64;
    exp_overrun = 0;
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (pcm_valid) extra++;
    end
    check("abort_no_valid", extra, 0);
    check("abort_pcm", int'(pcm_out), 8192);
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);

    for (int i = 0; i < NV; i++) vin[i] = rnd_voice();
    do_sample("post_rst_vol", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
